// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared switch types and constants
//
// Purpose: port/target geometry of the 4-port switch and the default
//          buffered packet record used by ingress buffering.
// Contents:
//   NUM_PORTS, PORT_ID_W, TARGET_W : switch geometry
//   PKT_DATA_W                     : default payload width (8)
//   pkt_t                          : {source, target, data} packet record
package switch_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int PORT_ID_W  = 2;
  localparam int TARGET_W   = 4;
  localparam int PKT_DATA_W = 8;

  typedef struct packed {
    logic [PORT_ID_W-1:0]  source;
    logic [TARGET_W-1:0]   target;
    logic [PKT_DATA_W-1:0] data;
  } pkt_t;

  // Number of destinations named by a target mask (0..TARGET_W).
  function automatic logic [2:0] target_count(input logic [TARGET_W-1:0] mask);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < TARGET_W; i++) begin
      n = n + {2'b00, mask[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ingress_fifo.sv
// rtl/ingress_fifo.sv - single-clock packet FIFO with occupancy counter
//
// Purpose: synchronous FIFO of packet records for the ingress stage.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push_i, wdata_i   : write request and entry (ignored while full)
//   pop_i             : remove head entry (ignored while empty)
//   rdata_o           : head entry, read from registered read pointer
//   full_o, empty_o   : occupancy flags from the registered level
//   level_o           : number of entries held
module ingress_fifo
  import switch_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = pkt_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  T                           wdata_i,
  input  logic                       pop_i,
  output T                           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  T                mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Flags come from registered state, so a same-cycle pop never frees
  // room for a push while full.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // DEPTH is a power of two, so pointers wrap by plain overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) begin
      level_d = level_q + LW'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: contents are only observed through level.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/switch_ingress_stage.sv
// rtl/switch_ingress_stage.sv - per-port ingress buffer with multicast head service
//
// Purpose: accepts packets from one external port, buffers them, presents the
//          head to the fabric which serves targets individually, and keeps
//          saturating accept/drop statistics.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   valid_in, source_in, target_in,
//   data_in                           : incoming packet
//   out_valid, out_source, out_target,
//   out_data                          : head packet; out_target = unserved targets
//   ack_mask                          : targets served by the fabric this cycle
//   fifo_full, fifo_empty, level      : buffer occupancy
//   clr_stats                         : zero all statistics counters
//   acc_pkts, drop_pkts, drop_targets : saturating statistics
module switch_ingress_stage
  import switch_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [PORT_ID_W-1:0]       source_in,
  input  logic [TARGET_W-1:0]        target_in,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       out_valid,
  output logic [PORT_ID_W-1:0]       out_source,
  output logic [TARGET_W-1:0]        out_target,
  output logic [DATA_W-1:0]          out_data,
  input  logic [TARGET_W-1:0]        ack_mask,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  input  logic                       clr_stats,
  output logic [CNT_W-1:0]           acc_pkts,
  output logic [CNT_W-1:0]           drop_pkts,
  output logic [CNT_W-1:0]           drop_targets
);

  localparam int SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Same layout as pkt_t, but with the payload width of this instance.
  typedef struct packed {
    logic [PORT_ID_W-1:0] source;
    logic [TARGET_W-1:0]  target;
    logic [DATA_W-1:0]    data;
  } entry_t;

  entry_t               wr_entry;
  entry_t               head;
  logic                 accept;
  logic                 drop;
  logic                 pop;
  logic [TARGET_W-1:0]  cur_rem;
  logic [TARGET_W-1:0]  rem_q, rem_d;
  logic                 rem_vld_q, rem_vld_d;
  logic [CNT_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     drop_q, drop_d;
  logic [CNT_W-1:0]     dtgt_q, dtgt_d;
  logic [SUM_W-1:0]     dtgt_sum;

  // ---------------------------------------------------------------------
  // Accept / drop decode
  // ---------------------------------------------------------------------
  assign accept = valid_in && !fifo_full && (target_in != '0);
  assign drop   = valid_in && !accept;

  assign wr_entry = '{source: source_in, target: target_in, data: data_in};

  ingress_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  // ---------------------------------------------------------------------
  // Head service
  // ---------------------------------------------------------------------
  // rem_vld_q clear means the head has just arrived and nothing has been
  // served yet, so its full stored target mask is the remaining set. This
  // loads the remaining mask without peeking at the entry behind the head.
  assign out_valid = !fifo_empty;
  assign cur_rem   = rem_vld_q ? rem_q : head.target;

  // Stray ack bits outside the remaining set fall out of the AND.
  assign pop = out_valid && ((cur_rem & ~ack_mask) == '0);

  always_comb begin
    rem_d     = '0;
    rem_vld_d = 1'b0;
    if (out_valid && !pop) begin
      rem_d     = cur_rem & ~ack_mask;
      rem_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      rem_vld_q <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      rem_vld_q <= rem_vld_d;
    end
  end

  // Head fields read as zero while the buffer is empty.
  assign out_source = out_valid ? head.source : '0;
  assign out_target = out_valid ? cur_rem     : '0;
  assign out_data   = out_valid ? head.data   : '0;

  // ---------------------------------------------------------------------
  // Saturating statistics
  // ---------------------------------------------------------------------
  // One spare bit catches overflow of the popcount add.
  assign dtgt_sum = {1'b0, dtgt_q} + SUM_W'(target_count(target_in));

  always_comb begin
    acc_d  = acc_q;
    drop_d = drop_q;
    dtgt_d = dtgt_q;
    if (clr_stats) begin
      acc_d  = '0;
      drop_d = '0;
      dtgt_d = '0;
    end else begin
      if (accept && (acc_q != CNT_MAX)) begin
        acc_d = acc_q + CNT_W'(1);
      end
      if (drop) begin
        if (drop_q != CNT_MAX) begin
          drop_d = drop_q + CNT_W'(1);
        end
        dtgt_d = dtgt_sum[CNT_W] ? CNT_MAX : dtgt_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      drop_q <= '0;
      dtgt_q <= '0;
    end else begin
      acc_q  <= acc_d;
      drop_q <= drop_d;
      dtgt_q <= dtgt_d;
    end
  end

  assign acc_pkts     = acc_q;
  assign drop_pkts    = drop_q;
  assign drop_targets = dtgt_q;

endmodule

// File: tb/tb_switch_ingress_stage.sv
// tb/tb_switch_ingress_stage.sv - self-checking bench for switch_ingress_stage
module tb_switch_ingress_stage;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [1:0] s;
    logic [3:0] t;
    logic [7:0] d;
  } mpkt_t;

  logic              clk;
  logic              rst;
  logic              valid_in;
  logic [1:0]        source_in;
  logic [3:0]        target_in;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic [1:0]        out_source;
  logic [3:0]        out_target;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        ack_mask;
  logic              fifo_full;
  logic              fifo_empty;
  logic [3:0]        level;
  logic              clr_stats;
  logic [CNT_W-1:0]  acc_pkts;
  logic [CNT_W-1:0]  drop_pkts;
  logic [CNT_W-1:0]  drop_targets;

  switch_ingress_stage #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .source_in    (source_in),
    .target_in    (target_in),
    .data_in      (data_in),
    .out_valid    (out_valid),
    .out_source   (out_source),
    .out_target   (out_target),
    .out_data     (out_data),
    .ack_mask     (ack_mask),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .level        (level),
    .clr_stats    (clr_stats),
    .acc_pkts     (acc_pkts),
    .drop_pkts    (drop_pkts),
    .drop_targets (drop_targets)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of buffered packets, unserved targets of head,
  // and plain integer counters clamped at CMAX.
  mpkt_t     mq[$];
  logic [3:0] m_rem;
  int        m_acc, m_drop, m_dt;
  int        n_checks;
  int        n_fail;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic compare_all();
    bit hv;
    hv = (mq.size() > 0);
    check("out_valid", 32'(out_valid), 32'(hv));
    check("out_source", 32'(out_source), hv ? 32'(mq[0].s) : 32'd0);
    check("out_target", 32'(out_target), hv ? 32'(m_rem) : 32'd0);
    check("out_data", 32'(out_data), hv ? 32'(mq[0].d) : 32'd0);
    check("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
    check("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
    check("level", 32'(level), 32'(mq.size()));
    check("acc_pkts", 32'(acc_pkts), 32'(m_acc));
    check("drop_pkts", 32'(drop_pkts), 32'(m_drop));
    check("drop_targets", 32'(drop_targets), 32'(m_dt));
  endtask

  // One clock cycle: drive inputs, step the model with the same inputs,
  // then compare every output 1 time unit after the edge.
  task automatic cyc(input logic r, input logic v, input logic [1:0] s, input logic [3:0] t,
                     input logic [7:0] d, input logic [3:0] a, input logic c);
    bit    was_full, was_empty, popped, acc_ok;
    mpkt_t p;
    rst = r; valid_in = v; source_in = s; target_in = t; data_in = d;
    ack_mask = a; clr_stats = c;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_rem = 4'h0; m_acc = 0; m_drop = 0; m_dt = 0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      popped    = 1'b0;
      acc_ok    = v && !was_full && (t != 4'h0);
      if (!was_empty) begin
        if ((m_rem & ~a) == 4'h0) popped = 1'b1;
        else m_rem = m_rem & ~a;
      end
      if (popped) void'(mq.pop_front());
      if (acc_ok) begin
        p.s = s; p.t = t; p.d = d;
        mq.push_back(p);
      end
      if (mq.size() > 0 && (popped || was_empty)) m_rem = mq[0].t;
      if (c) begin
        m_acc = 0; m_drop = 0; m_dt = 0;
      end else begin
        if (acc_ok && m_acc < CMAX) m_acc++;
        if (v && !acc_ok) begin
          if (m_drop < CMAX) m_drop++;
          m_dt = m_dt + $countones(t);
          if (m_dt > CMAX) m_dt = CMAX;
        end
      end
    end
    #1;
    compare_all();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_rem = 4'h0; m_acc = 0; m_drop = 0; m_dt = 0;
    rst = 1'b1; valid_in = 1'b0; source_in = 2'd0; target_in = 4'h0;
    data_in = 8'h00; ack_mask = 4'h0; clr_stats = 1'b0;

    // Reset state
    cyc(1, 0, 0, 4'h0, 8'h00, 4'h0, 0);
    cyc(0, 0, 0, 4'h0, 8'h00, 4'h0, 0);
    check("reset_empty", 32'(fifo_empty), 32'd1);

    // Unicast sequence, each acked fully on first presentation
    cyc(0, 1, 2'd1, 4'b0010, 8'hA1, 4'h0, 0);
    check("uni_t0", 32'(out_target), 32'b0010);
    check("uni_lat", 32'(out_valid), 32'd1);
    cyc(0, 1, 2'd2, 4'b0100, 8'hA2, 4'b0010, 0);
    check("uni_t1", 32'(out_target), 32'b0100);
    cyc(0, 1, 2'd3, 4'b1000, 8'hA3, 4'b0100, 0);
    check("uni_t2", 32'(out_target), 32'b1000);
    cyc(0, 0, 2'd0, 4'h0, 8'h00, 4'b1000, 0);
    check("uni_level", 32'(level), 32'd0);
    check("uni_acc", 32'(acc_pkts), 32'd3);
    check("uni_drop", 32'(drop_pkts), 32'd0);

    // Multicast partial service, with a follower queued behind it
    cyc(0, 1, 2'd0, 4'b1011, 8'hB0, 4'h0, 0);
    check("mc_t0", 32'(out_target), 32'b1011);
    cyc(0, 1, 2'd2, 4'b0101, 8'hB1, 4'b0001, 0);
    check("mc_t1", 32'(out_target), 32'b1010);
    cyc(0, 0, 2'd0, 4'h0, 8'h00, 4'b1000, 0);
    check("mc_t2", 32'(out_target), 32'b0010);
    cyc(0, 0, 2'd0, 4'h0, 8'h00, 4'b0010, 0);
    check("mc_next", 32'(out_target), 32'b0101);
    check("mc_next_data", 32'(out_data), 32'hB1);
    cyc(0, 0, 2'd0, 4'h0, 8'h00, 4'b0101, 0);

    // Fill to capacity, then two drops on full
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, 2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), 8'($urandom), 4'h0, 0);
    end
    cyc(0, 1, 2'd1, 4'b0111, 8'hC0, 4'h0, 0);
    cyc(0, 1, 2'd2, 4'b1111, 8'hC1, 4'h0, 0);
    check("full_flag", 32'(fifo_full), 32'd1);
    check("full_drop", 32'(drop_pkts), 32'd2);
    check("full_dtgt", 32'(drop_targets), 32'd7);
    check("full_level", 32'(level), 32'd8);

    // Pop and write in the same cycle while full: write still dropped
    cyc(0, 1, 2'd3, 4'b0001, 8'hC2, 4'hF, 0);
    check("popfull_drop", 32'(drop_pkts), 32'd3);
    check("popfull_level", 32'(level), 32'd7);

    // Null target drops, then saturation, then clear beside a drop
    cyc(0, 1, 2'd0, 4'h0, 8'hD0, 4'h0, 0);
    check("null_drop", 32'(drop_pkts), 32'd4);
    check("null_dtgt", 32'(drop_targets), 32'd8);
    check("null_level", 32'(level), 32'd7);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 2'd0, 4'h0, 8'(i), 4'h0, 0);
    end
    check("drop_sat", 32'(drop_pkts), 32'd15);
    cyc(0, 1, 2'd0, 4'h0, 8'hD1, 4'h0, 1);
    check("clr_acc", 32'(acc_pkts), 32'd0);
    check("clr_drop", 32'(drop_pkts), 32'd0);
    check("clr_dtgt", 32'(drop_targets), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(0,
          1'($urandom_range(0, 9) < 7),
          2'($urandom_range(0, 3)),
          4'($urandom_range(0, 15)),
          8'($urandom),
          ($urandom_range(0, 2) == 0) ? 4'h0 :
          ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 49) == 0));
    end

    // Reset with buffered entries and a partially served head
    cyc(1, 0, 0, 4'h0, 8'h00, 4'h0, 0);
    cyc(0, 1, 2'd1, 4'b1111, 8'hE0, 4'h0, 0);
    cyc(0, 1, 2'd2, 4'b0011, 8'hE1, 4'h0, 0);
    cyc(0, 1, 2'd3, 4'b0110, 8'hE2, 4'b0001, 0);
    check("pre_rst_t", 32'(out_target), 32'b1110);
    cyc(1, 1, 2'd0, 4'h0, 8'hE3, 4'h0, 0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_acc", 32'(acc_pkts), 32'd0);
    check("rst_drop", 32'(drop_pkts), 32'd0);
    cyc(0, 1, 2'd2, 4'b0100, 8'hE4, 4'h0, 0);
    check("post_rst_t", 32'(out_target), 32'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
